// File: rtl/demux_1x8_core.sv
// 1-to-2^SIZE demultiplexer: routes din onto the line addressed by sel.
// Provides a combinational output plus a registered copy of output, select and data.
module demux_1x8_core #(
    parameter int SIZE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    input  logic [SIZE-1:0]       sel,
    output logic [(2**SIZE)-1:0]  dout,
    output logic [(2**SIZE)-1:0]  dout_q,
    output logic [SIZE-1:0]       sel_q,
    output logic                  din_q
);

    localparam int N = 2**SIZE;

    // Every sel value maps to exactly one line because N = 2^SIZE.
    always_comb begin
        // NOTE: assign the default before the loop so every bit is always driven and no latch is inferred.
        dout = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SIZE'(k)) begin
                dout[k] = din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            dout_q <= '0;
            sel_q  <= '0;
            din_q  <= 1'b0;
        end else begin
            dout_q <= dout;
            sel_q  <= sel;
            din_q  <= din;
        end
    end

endmodule

// File: tb/tb_demux_1x8_core.sv
// Scoreboard bench for demux_1x8_core: stimulus queues expectations, a monitor
// pops and compares them against the DUT outputs.
module tb_demux_1x8_core;

    typedef enum int {S_DOUT, S_DOUT_Q, S_SEL_Q, S_DIN_Q, S_DOUT2} sig_e;

    typedef struct {
        sig_e       sig;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   n_pass  = 0;
    int   n_total = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic [2:0] sel = 3'd0;
    logic [7:0] dout;
    logic [7:0] dout_q;
    logic [2:0] sel_q;
    logic       din_q;

    logic       din2 = 1'b0;
    logic [1:0] sel2 = 2'd0;
    logic [3:0] dout2;
    logic [3:0] dout_q2;
    logic [1:0] sel_q2;
    logic       din_q2;

    // Hand-computed one-hot patterns for sel = 0..7 and sel = 0..3.
    logic [7:0] sweep8 [8] = '{8'b00000001, 8'b00000010, 8'b00000100, 8'b00001000,
                               8'b00010000, 8'b00100000, 8'b01000000, 8'b10000000};
    logic [7:0] sweep4 [4] = '{8'b00000001, 8'b00000010, 8'b00000100, 8'b00001000};

    always #5 clk = ~clk;

    demux_1x8_core dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .sel    (sel),
        .dout   (dout),
        .dout_q (dout_q),
        .sel_q  (sel_q),
        .din_q  (din_q)
    );

    demux_1x8_core #(2) dut2 (
        .clk    (clk),
        .rst    (rst),
        .din    (din2),
        .sel    (sel2),
        .dout   (dout2),
        .dout_q (dout_q2),
        .sel_q  (sel_q2),
        .din_q  (din_q2)
    );

    task automatic push(input sig_e sig, input logic [7:0] exp, input string name);
        exp_t e;
        e.sig  = sig;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Hand the queued expectations to the monitor, then step off the sample point.
    task automatic flush();
        -> chk_ev;
        #1;
    endtask

    // Monitor: compares each queued expectation against the presented DUT value.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.sig)
                    S_DOUT:   act = dout;
                    S_DOUT_Q: act = dout_q;
                    S_SEL_Q:  act = {5'b0, sel_q};
                    S_DIN_Q:  act = {7'b0, din_q};
                    default:  act = {4'b0, dout2};
                endcase
                n_total++;
                if (act === e.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state with idle inputs.
        #2;
        push(S_DOUT,   8'h00, "idle_dout");
        push(S_DOUT_Q, 8'h00, "reset_dout_q");
        push(S_SEL_Q,  8'h00, "reset_sel_q");
        push(S_DIN_Q,  8'h00, "reset_din_q");
        flush();

        // Combinational path works under reset; registers hold through an edge.
        din = 1'b1;
        sel = 3'd3;
        @(posedge clk);
        #1;
        push(S_DOUT,   8'b00001000, "rst_comb_dout");
        push(S_DOUT_Q, 8'h00,       "rst_hold_dout_q");
        flush();

        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            din = 1'b1;
            sel = 3'(s);
            #2;
            push(S_DOUT, sweep8[s], $sformatf("sweep_hi_sel%0d", s));
            flush();
        end

        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            din = 1'b0;
            sel = 3'(s);
            #2;
            push(S_DOUT, 8'h00, $sformatf("sweep_lo_sel%0d", s));
            flush();
        end

        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            din2 = 1'b1;
            sel2 = 2'(s);
            #2;
            push(S_DOUT2, sweep4[s], $sformatf("size2_sel%0d", s));
            flush();
        end

        // Registered path: capture, then change sel between edges.
        @(negedge clk);
        din = 1'b1;
        sel = 3'd5;
        @(posedge clk);
        #1;
        push(S_DOUT_Q, 8'b00100000, "reg_dout_q_sel5");
        push(S_SEL_Q,  8'd5,        "reg_sel_q_5");
        push(S_DIN_Q,  8'd1,        "reg_din_q_1");
        flush();
        sel = 3'd2;
        #1;
        push(S_DOUT,   8'b00000100, "comb_dout_sel2");
        push(S_DOUT_Q, 8'b00100000, "reg_hold_dout_q");
        flush();
        @(posedge clk);
        #1;
        push(S_DOUT_Q, 8'b00000100, "reg_dout_q_sel2");
        push(S_SEL_Q,  8'd2,        "reg_sel_q_2");
        flush();

        // Asynchronous reset between edges, then reload.
        @(negedge clk);
        sel = 3'd7;
        @(posedge clk);
        #1;
        push(S_DOUT_Q, 8'b10000000, "pre_rst_dout_q");
        flush();
        #1;
        rst = 1'b1;
        #1;
        push(S_DOUT_Q, 8'h00,       "async_rst_dout_q");
        push(S_SEL_Q,  8'h00,       "async_rst_sel_q");
        push(S_DIN_Q,  8'h00,       "async_rst_din_q");
        push(S_DOUT,   8'b10000000, "async_rst_comb_dout");
        flush();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(S_DOUT_Q, 8'b10000000, "reload_dout_q");
        push(S_SEL_Q,  8'd7,        "reload_sel_q");
        push(S_DIN_Q,  8'd1,        "reload_din_q");
        flush();

        #2;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
